// File: rtl/goboard_coord_entry.sv
// goboard_coord_entry: PS/2 coordinate-entry controller for the Go board.
// Parses break/extended prefixes from decoded scan codes, and builds a cursor
// from a column letter plus a 1-2 digit row. Moves are committed to the game
// logic over a valid/ready handshake.
// Optional feature: define GOBOARD_CURSOR_KEYS_EN for arrow-key navigation.
// Ports:
//   clk, clr_n (async active-low)
//   code_rdy, code_parity_err, code[7:0] : byte stream from the keyboard rx
//   sel_x, sel_y                         : live cursor (0-based)
//   move_valid, move_ready, move_x/y     : committed-move handshake
//   entry_err                            : one-cycle error pulse
module goboard_coord_entry #(
  parameter int unsigned BOARD_N = 19,
  parameter int unsigned COORD_W = 5,
  parameter int unsigned SKIP_I  = 1
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               code_rdy,
  input  logic               code_parity_err,
  input  logic [7:0]         code,
  output logic [COORD_W-1:0] sel_x,
  output logic [COORD_W-1:0] sel_y,
  output logic               move_valid,
  input  logic               move_ready,
  output logic [COORD_W-1:0] move_x,
  output logic [COORD_W-1:0] move_y,
  output logic               entry_err
);

  localparam logic [8:0] BOARD_N9  = 9'(BOARD_N);
  localparam logic [7:0] CODE_BRK  = 8'hF0;
  localparam logic [7:0] CODE_EXT  = 8'hE0;
  localparam logic [7:0] CODE_BKSP = 8'h66;
  localparam logic [7:0] CODE_ESC  = 8'h76;
  localparam logic [7:0] CODE_ENT  = 8'h5A;

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK} state_t;

  state_t state, state_nxt;

  logic       rdy_d;
  logic       ev_q, perr_q;
  logic [7:0] code_q;
  logic       col_ok, col_ok_nxt;
  logic       row_ok, row_ok_nxt;
  logic [4:0] acc, acc_nxt;

  logic [COORD_W-1:0] sel_x_nxt, sel_y_nxt, move_x_nxt, move_y_nxt;
  logic               move_valid_nxt, entry_err_nxt;

  logic       accept;
  logic [5:0] lt;        // {valid, letter ordinal A=0..Z=25}
  logic [4:0] dg;        // {valid, digit value}
  logic [4:0] col_idx;
  logic       col_legal;
  logic [8:0] row_n;

`ifdef GOBOARD_CURSOR_KEYS_EN
  logic [COORD_W-1:0] cur_x, cur_y;
  logic               cur_hit;
`endif

  // Letter scan code -> {valid, ordinal}
  function automatic logic [5:0] letter_ord(input logic [7:0] c);
    case (c)
      8'h1C: return {1'b1, 5'd0};
      8'h32: return {1'b1, 5'd1};
      8'h21: return {1'b1, 5'd2};
      8'h23: return {1'b1, 5'd3};
      8'h24: return {1'b1, 5'd4};
      8'h2B: return {1'b1, 5'd5};
      8'h34: return {1'b1, 5'd6};
      8'h33: return {1'b1, 5'd7};
      8'h43: return {1'b1, 5'd8};
      8'h3B: return {1'b1, 5'd9};
      8'h42: return {1'b1, 5'd10};
      8'h4B: return {1'b1, 5'd11};
      8'h3A: return {1'b1, 5'd12};
      8'h31: return {1'b1, 5'd13};
      8'h44: return {1'b1, 5'd14};
      8'h4D: return {1'b1, 5'd15};
      8'h15: return {1'b1, 5'd16};
      8'h2D: return {1'b1, 5'd17};
      8'h1B: return {1'b1, 5'd18};
      8'h2C: return {1'b1, 5'd19};
      8'h3C: return {1'b1, 5'd20};
      8'h2A: return {1'b1, 5'd21};
      8'h1D: return {1'b1, 5'd22};
      8'h22: return {1'b1, 5'd23};
      8'h35: return {1'b1, 5'd24};
      8'h1A: return {1'b1, 5'd25};
      default: return 6'd0;
    endcase
  endfunction

  // Digit scan code -> {valid, value}
  function automatic logic [4:0] digit_val(input logic [7:0] c);
    case (c)
      8'h45: return {1'b1, 4'd0};
      8'h16: return {1'b1, 4'd1};
      8'h1E: return {1'b1, 4'd2};
      8'h26: return {1'b1, 4'd3};
      8'h25: return {1'b1, 4'd4};
      8'h2E: return {1'b1, 4'd5};
      8'h36: return {1'b1, 4'd6};
      8'h3D: return {1'b1, 4'd7};
      8'h3E: return {1'b1, 4'd8};
      8'h46: return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  // Input stage: edge-detect code_rdy and capture the byte for the next cycle
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rdy_d  <= 1'b1;
      ev_q   <= 1'b0;
      perr_q <= 1'b0;
      code_q <= 8'h00;
    end else begin
      rdy_d  <= code_rdy;
      ev_q   <= code_rdy & ~rdy_d;
      perr_q <= code_parity_err;
      code_q <= code;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= S_IDLE;
      col_ok     <= 1'b0;
      row_ok     <= 1'b0;
      acc        <= 5'd0;
      sel_x      <= '0;
      sel_y      <= '0;
      move_x     <= '0;
      move_y     <= '0;
      move_valid <= 1'b0;
      entry_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      col_ok     <= col_ok_nxt;
      row_ok     <= row_ok_nxt;
      acc        <= acc_nxt;
      sel_x      <= sel_x_nxt;
      sel_y      <= sel_y_nxt;
      move_x     <= move_x_nxt;
      move_y     <= move_y_nxt;
      move_valid <= move_valid_nxt;
      entry_err  <= entry_err_nxt;
    end
  end

  // Prefix FSM, key actions and handshake
  always_comb begin
    state_nxt      = state;
    col_ok_nxt     = col_ok;
    row_ok_nxt     = row_ok;
    acc_nxt        = acc;
    sel_x_nxt      = sel_x;
    sel_y_nxt      = sel_y;
    move_x_nxt     = move_x;
    move_y_nxt     = move_y;
    entry_err_nxt  = 1'b0;
    accept         = move_valid & move_ready;
    move_valid_nxt = move_valid & ~accept;

    lt = letter_ord(code_q);
    dg = digit_val(code_q);
    // With I skipped, letters after I shift down by one column
    if ((SKIP_I != 0) && (lt[4:0] > 5'd8)) col_idx = lt[4:0] - 5'd1;
    else                                    col_idx = lt[4:0];
    col_legal = lt[5] && !((SKIP_I != 0) && (lt[4:0] == 5'd8))
                && (9'(col_idx) < BOARD_N9);
    row_n = 9'(acc) * 9'd10 + 9'(dg[3:0]);

`ifdef GOBOARD_CURSOR_KEYS_EN
    cur_x   = sel_x;
    cur_y   = sel_y;
    cur_hit = 1'b0;
    case (code_q)
      8'h75: begin
        cur_hit = 1'b1;
        if (9'(sel_y) < BOARD_N9 - 9'd1) cur_y = sel_y + COORD_W'(1);
      end
      8'h72: begin
        cur_hit = 1'b1;
        if (sel_y != '0) cur_y = sel_y - COORD_W'(1);
      end
      8'h6B: begin
        cur_hit = 1'b1;
        if (sel_x != '0) cur_x = sel_x - COORD_W'(1);
      end
      8'h74: begin
        cur_hit = 1'b1;
        if (9'(sel_x) < BOARD_N9 - 9'd1) cur_x = sel_x + COORD_W'(1);
      end
      default: ;
    endcase
`endif

    if (ev_q) begin
      if (perr_q) begin
        state_nxt     = S_IDLE;
        entry_err_nxt = 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (code_q == CODE_BRK)      state_nxt = S_BRK;
            else if (code_q == CODE_EXT) state_nxt = S_EXT;
          end
          S_BRK: begin
            state_nxt = S_IDLE;
            if (lt[5]) begin
              if (col_legal) begin
                sel_x_nxt  = COORD_W'(col_idx);
                col_ok_nxt = 1'b1;
                acc_nxt    = 5'd0;
                row_ok_nxt = 1'b0;
              end else begin
                entry_err_nxt = 1'b1;
              end
            end else if (dg[4]) begin
              if (row_n <= BOARD_N9) begin
                acc_nxt = row_n[4:0];
                // A leading zero leaves the row incomplete
                if (row_n != 9'd0) begin
                  row_ok_nxt = 1'b1;
                  sel_y_nxt  = COORD_W'(row_n - 9'd1);
                end else begin
                  row_ok_nxt = 1'b0;
                end
              end else begin
                entry_err_nxt = 1'b1;
              end
            end else if (code_q == CODE_BKSP) begin
              acc_nxt    = 5'd0;
              row_ok_nxt = 1'b0;
            end else if (code_q == CODE_ESC) begin
              acc_nxt    = 5'd0;
              col_ok_nxt = 1'b0;
              row_ok_nxt = 1'b0;
            end else if (code_q == CODE_ENT) begin
              // Accept when the slot is free or being drained this cycle
              if (col_ok && row_ok && (!move_valid || accept)) begin
                move_x_nxt     = sel_x;
                move_y_nxt     = sel_y;
                move_valid_nxt = 1'b1;
                col_ok_nxt     = 1'b0;
                row_ok_nxt     = 1'b0;
                acc_nxt        = 5'd0;
              end else begin
                entry_err_nxt = 1'b1;
              end
            end
          end
          S_EXT: begin
            state_nxt = (code_q == CODE_BRK) ? S_EXTBRK : S_IDLE;
          end
          S_EXTBRK: begin
            state_nxt = S_IDLE;
`ifdef GOBOARD_CURSOR_KEYS_EN
            if (cur_hit) begin
              sel_x_nxt  = cur_x;
              sel_y_nxt  = cur_y;
              col_ok_nxt = 1'b1;
              row_ok_nxt = 1'b1;
              acc_nxt    = 5'(9'(cur_y) + 9'd1);
            end
`endif
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_goboard_coord_entry.sv
// Directed bench for goboard_coord_entry: BOARD_N=19 main instance plus a
// BOARD_N=9 instance sharing the same byte stream for the column-range check.
module tb_goboard_coord_entry;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr_n, code_rdy, code_parity_err, move_ready;
  logic [7:0] code;

  logic [4:0] sel_x, sel_y, move_x, move_y;
  logic       move_valid, entry_err;

  logic [3:0] s9_sel_x, s9_sel_y, s9_move_x, s9_move_y;
  logic       s9_move_valid, s9_entry_err;

  int n_cmp = 0;
  int n_bad = 0;

  goboard_coord_entry #(.BOARD_N(19), .COORD_W(5), .SKIP_I(1)) dut (
    .clk(clk), .clr_n(clr_n), .code_rdy(code_rdy),
    .code_parity_err(code_parity_err), .code(code),
    .sel_x(sel_x), .sel_y(sel_y), .move_valid(move_valid),
    .move_ready(move_ready), .move_x(move_x), .move_y(move_y),
    .entry_err(entry_err)
  );

  goboard_coord_entry #(.BOARD_N(9), .COORD_W(4), .SKIP_I(1)) dut9 (
    .clk(clk), .clr_n(clr_n), .code_rdy(code_rdy),
    .code_parity_err(code_parity_err), .code(code),
    .sel_x(s9_sel_x), .sel_y(s9_sel_y), .move_valid(s9_move_valid),
    .move_ready(1'b0), .move_x(s9_move_x), .move_y(s9_move_y),
    .entry_err(s9_entry_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One byte event; move_ready is driven only for the processing edge.
  // Starts and ends on a negedge; results are visible on return.
  task automatic send(input logic [7:0] b, input logic perr, input logic rdy);
    code            = b;
    code_parity_err = perr;
    code_rdy        = 1'b1;
    @(negedge clk);
    code_rdy        = 1'b0;
    code_parity_err = 1'b0;
    move_ready      = rdy;
    @(negedge clk);
    move_ready      = 1'b0;
  endtask

  task automatic rel(input logic [7:0] sc, input logic rdy);
    send(8'hF0, 1'b0, 1'b0);
    send(sc, 1'b0, rdy);
  endtask

  task automatic xrel(input logic [7:0] sc);
    send(8'hE0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    send(sc, 1'b0, 1'b0);
  endtask

  initial begin
    clr_n = 1'b0; code_rdy = 1'b1; code = 8'hF0;
    code_parity_err = 1'b0; move_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sel_x", sel_x, 0);
    chk("rst_sel_y", sel_y, 0);
    chk("rst_move_x", move_x, 0);
    chk("rst_move_y", move_y, 0);
    chk("rst_move_valid", move_valid, 0);
    chk("rst_entry_err", entry_err, 0);

    // code_rdy high through reset release: the held F0 must not count
    clr_n = 1'b1;
    repeat (3) @(negedge clk);
    code_rdy = 1'b0;
    @(negedge clk);
    send(8'h3B, 1'b0, 1'b0);
    chk("held_rdy_no_event", sel_x, 0);

    // J 1 5 Enter
    rel(8'h3B, 1'b0); rel(8'h16, 1'b0); rel(8'h2E, 1'b0);
    chk("j15_sel_x", sel_x, 8);
    chk("j15_sel_y", sel_y, 14);
    chk("j15_no_move", move_valid, 0);
    rel(8'h5A, 1'b0);
    chk("j15_mv", move_valid, 1);
    chk("j15_mx", move_x, 8);
    chk("j15_my", move_y, 14);
    chk("j15_no_err", entry_err, 0);
    move_ready = 1'b1; @(negedge clk); move_ready = 1'b0;
    chk("j15_drained", move_valid, 0);

    // T 2 0 -> row 20 out of range
    rel(8'h2C, 1'b0);
    chk("t_sel_x", sel_x, 18);
    rel(8'h1E, 1'b0);
    chk("t2_sel_y", sel_y, 1);
    rel(8'h45, 1'b0);
    chk("t20_err", entry_err, 1);
    chk("t20_sel_y", sel_y, 1);
    @(negedge clk);
    chk("t20_err_pulse_1cyc", entry_err, 0);

    // I is illegal with SKIP_I=1
    rel(8'h43, 1'b0);
    chk("i_err", entry_err, 1);
    chk("i_sel_x", sel_x, 18);

    // K: column 9, legal on 19x19, out of range on 9x9
    rel(8'h42, 1'b0);
    chk("k_err_n9", s9_entry_err, 1);
    chk("k_no_err_n19", entry_err, 0);
    chk("k_sel_x_n19", sel_x, 9);

    // E 0 1 9 0: leading zero, top row, then overflow
    rel(8'h24, 1'b0);
    chk("e_sel_x", sel_x, 4);
    rel(8'h45, 1'b0);
    chk("lead0_no_err", entry_err, 0);
    chk("lead0_sel_y", sel_y, 1);
    rel(8'h16, 1'b0);
    chk("row01_sel_y", sel_y, 0);
    rel(8'h46, 1'b0);
    chk("row19_sel_y", sel_y, 18);
    rel(8'h45, 1'b0);
    chk("row190_err", entry_err, 1);
    chk("row190_sel_y", sel_y, 18);

    // Backspace clears the row; Enter must then fail
    rel(8'h66, 1'b0);
    rel(8'h5A, 1'b0);
    chk("bksp_enter_err", entry_err, 1);
    chk("bksp_no_move", move_valid, 0);

    // D 4 Enter -> pending (3,3)
    rel(8'h23, 1'b0); rel(8'h25, 1'b0); rel(8'h5A, 1'b0);
    chk("d4_mv", move_valid, 1);
    chk("d4_mx", move_x, 3);
    chk("d4_my", move_y, 3);
    // C 3 Enter while pending and not ready
    rel(8'h21, 1'b0); rel(8'h26, 1'b0); rel(8'h5A, 1'b0);
    chk("busy_err", entry_err, 1);
    chk("busy_mx", move_x, 3);
    chk("busy_my", move_y, 3);
    chk("busy_mv", move_valid, 1);
    // Enter again with ready on the processing edge
    rel(8'h5A, 1'b1);
    chk("swap_no_err", entry_err, 0);
    chk("swap_mv", move_valid, 1);
    chk("swap_mx", move_x, 2);
    chk("swap_my", move_y, 2);
    move_ready = 1'b1; @(negedge clk); move_ready = 1'b0;
    chk("swap_drained", move_valid, 0);

    // Parity error between F0 and 1C
    send(8'hF0, 1'b0, 1'b0);
    send(8'h1C, 1'b1, 1'b0);
    chk("perr_err", entry_err, 1);
    send(8'h1C, 1'b0, 1'b0);
    chk("perr_followup_no_err", entry_err, 0);
    chk("perr_followup_ignored", sel_x, 2);
    rel(8'h1C, 1'b0);
    chk("a_sel_x", sel_x, 0);
    rel(8'h76, 1'b0);
    rel(8'h5A, 1'b0);
    chk("esc_enter_err", entry_err, 1);

    // B 2 Enter -> pending (1,1), then reset while in S_EXTBRK
    rel(8'h32, 1'b0); rel(8'h1E, 1'b0); rel(8'h5A, 1'b0);
    chk("b2_mv", move_valid, 1);
    chk("b2_mx", move_x, 1);
    chk("b2_my", move_y, 1);
    send(8'hE0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    #2 clr_n = 1'b0;
    #1;
    chk("arst_sel_x", sel_x, 0);
    chk("arst_sel_y", sel_y, 0);
    chk("arst_move_x", move_x, 0);
    chk("arst_move_y", move_y, 0);
    chk("arst_move_valid", move_valid, 0);
    chk("arst_entry_err", entry_err, 0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);

`ifdef GOBOARD_CURSOR_KEYS_EN
    xrel(8'h6B);
    chk("left_clamp_x", sel_x, 0);
    chk("left_clamp_y", sel_y, 0);
    chk("left_clamp_no_err", entry_err, 0);
    xrel(8'h74);
    xrel(8'h74);
    chk("right2_x", sel_x, 2);
    rel(8'h5A, 1'b0);
    chk("cur_mv", move_valid, 1);
    chk("cur_mx", move_x, 2);
    chk("cur_my", move_y, 0);
`else
    xrel(8'h74);
    chk("ext_ignored_x", sel_x, 0);
    rel(8'h5A, 1'b0);
    chk("ext_ignored_enter_err", entry_err, 1);
    chk("ext_ignored_no_move", move_valid, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
